// File: rtl/weight_pingpong_bank.sv
// Double-buffered weight/bias store. Words load into the shadow bank while the active bank is read.
// Define WEIGHT_BANK_DEBUG_CNT_EN to enable the accepted-write counter on debug_write_cnt.
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 8
`endif
`ifndef PE_CORE_NUM
`define PE_CORE_NUM 4
`endif

module weight_pingpong_bank #(
  parameter int WEIGHT_WIDTH = `WEIGHT_WIDTH,
  parameter int PE_CORE_NUM  = `PE_CORE_NUM
) (
  input  logic                                system_clk,
  input  logic                                rst_n,
  input  logic [PE_CORE_NUM*WEIGHT_WIDTH-1:0] weight_bias_input_data,
  input  logic [8:0]                          weight_bias_input_valid,
  output logic                                load_ready,
  input  logic                                swap_req,
  output logic                                swap_ack,
  input  logic                                rd_en,
  input  logic [2:0]                          rd_group,
  input  logic [3:0]                          rd_tap,
  output logic [PE_CORE_NUM*WEIGHT_WIDTH-1:0] rd_data,
  output logic                                rd_valid,
  output logic [PE_CORE_NUM*WEIGHT_WIDTH-1:0] active_bias,
  output logic                                bank_error,
  output logic [31:0]                         debug_write_cnt
);

  localparam int DW = PE_CORE_NUM * WEIGHT_WIDTH;

  typedef enum logic [1:0] {EMPTY, LOADING, FULL, SWAP} state_t;

  state_t state, state_next;

  logic [DW-1:0] bank_mem [0:1][0:7][0:8];
  logic [DW-1:0] shadow_bias;
  logic          active_sel;
  logic [3:0]    tap_cnt  [0:7];
  logic [3:0]    tap_next [0:7];
  logic [7:0]    loaded, loaded_next;
  logic          bias_loaded, bias_loaded_next;
  logic          tap_busy_next;

  logic          multi_hot;
  logic          bias_wr;
  logic          weight_wr;
  logic          weight_accept;
  logic          weight_reject;
  logic          rd_tap_bad;
  logic [2:0]    wr_group;

  // x & (x-1) is nonzero exactly when more than one valid bit is set
  assign multi_hot     = |(weight_bias_input_valid & (weight_bias_input_valid - 9'd1));
  assign bias_wr       = (weight_bias_input_valid == 9'h100);
  assign weight_wr     = !multi_hot && (|weight_bias_input_valid[7:0]);
  assign load_ready    = (state != FULL) && (state != SWAP);
  assign weight_accept = weight_wr && load_ready && !loaded[wr_group];
  assign weight_reject = weight_wr && !weight_accept;
  assign rd_tap_bad    = rd_en && (rd_tap > 4'd8);

  always_comb begin
    wr_group = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (weight_bias_input_valid[i]) wr_group = 3'(i);
    end
  end

  always_comb begin
    loaded_next = loaded;
    for (int i = 0; i < 8; i++) tap_next[i] = tap_cnt[i];
    if (state == SWAP) begin
      loaded_next = '0;
      for (int i = 0; i < 8; i++) tap_next[i] = 4'd0;
    end else if (weight_accept) begin
      if (tap_cnt[wr_group] == 4'd8) begin
        tap_next[wr_group]    = 4'd0;
        loaded_next[wr_group] = 1'b1;
      end else begin
        tap_next[wr_group] = tap_cnt[wr_group] + 4'd1;
      end
    end
  end

  always_comb begin
    tap_busy_next = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tap_next[i] != 4'd0) tap_busy_next = 1'b1;
    end
  end

  // A bias write landing in the SWAP cycle re-arms bias_loaded after the copy
  always_comb begin
    state_next       = state;
    bias_loaded_next = bias_loaded;
    case (state)
      SWAP: begin
        state_next       = EMPTY;
        bias_loaded_next = 1'b0;
      end
      FULL: begin
        if (swap_req) state_next = SWAP;
      end
      default: begin
        if (&loaded_next)                        state_next = FULL;
        else if ((|loaded_next) || tap_busy_next) state_next = LOADING;
        else                                      state_next = EMPTY;
      end
    endcase
    if (bias_wr) bias_loaded_next = 1'b1;
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      active_sel  <= 1'b0;
      loaded      <= '0;
      bias_loaded <= 1'b0;
      active_bias <= '0;
      swap_ack    <= 1'b0;
      bank_error  <= 1'b0;
      for (int i = 0; i < 8; i++) tap_cnt[i] <= 4'd0;
    end else begin
      state       <= state_next;
      loaded      <= loaded_next;
      bias_loaded <= bias_loaded_next;
      swap_ack    <= (state_next == SWAP);
      for (int i = 0; i < 8; i++) tap_cnt[i] <= tap_next[i];
      if (state == SWAP) begin
        active_sel <= ~active_sel;
        if (bias_loaded) active_bias <= shadow_bias;
      end
      if (multi_hot || weight_reject || rd_tap_bad) bank_error <= 1'b1;
    end
  end

  // Reads sample active_sel before the SWAP toggle takes effect
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_tap > 4'd8) rd_data <= '0;
        else               rd_data <= bank_mem[active_sel][rd_group][rd_tap];
      end
    end
  end

  always_ff @(posedge system_clk) begin
    if (weight_accept) bank_mem[~active_sel][wr_group][tap_cnt[wr_group]] <= weight_bias_input_data;
    if (bias_wr) shadow_bias <= weight_bias_input_data;
  end

`ifdef WEIGHT_BANK_DEBUG_CNT_EN
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) debug_write_cnt <= 32'd0;
    else if (weight_accept || bias_wr) debug_write_cnt <= debug_write_cnt + 32'd1;
  end
`else
  assign debug_write_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_weight_pingpong_bank.sv
// Directed plus randomized bench for weight_pingpong_bank, checked against a behavioural model.
module tb_weight_pingpong_bank;
  localparam int WW = 8;
  localparam int PN = 4;
  localparam int DW = WW * PN;

  logic          system_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] data_in;
  logic [8:0]    valid_in;
  logic          load_ready;
  logic          swap_req;
  logic          swap_ack;
  logic          rd_en;
  logic [2:0]    rd_group;
  logic [3:0]    rd_tap;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [DW-1:0] active_bias;
  logic          bank_error;
  logic [31:0]   debug_write_cnt;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model: per-group write counts (9 = group complete) and two word arrays
  logic [DW-1:0] m_bank [2][8][9];
  int            m_cnt [8];
  bit            m_bank_ok [2];
  bit            m_sel, m_swapping, m_err, m_bias_pend, m_rd_valid, m_ack, m_ready;
  logic [DW-1:0] m_shadow_bias, m_active_bias, m_rd_data;
  logic [31:0]   m_accepted;

  weight_pingpong_bank #(.WEIGHT_WIDTH(WW), .PE_CORE_NUM(PN)) dut (
    .system_clk              (system_clk),
    .rst_n                   (rst_n),
    .weight_bias_input_data  (data_in),
    .weight_bias_input_valid (valid_in),
    .load_ready              (load_ready),
    .swap_req                (swap_req),
    .swap_ack                (swap_ack),
    .rd_en                   (rd_en),
    .rd_group                (rd_group),
    .rd_tap                  (rd_tap),
    .rd_data                 (rd_data),
    .rd_valid                (rd_valid),
    .active_bias             (active_bias),
    .bank_error              (bank_error),
    .debug_write_cnt         (debug_write_cnt)
  );

  always #5 system_clk = ~system_clk;

  function automatic bit allFull();
    bit f = 1'b1;
    for (int g = 0; g < 8; g++) if (m_cnt[g] != 9) f = 1'b0;
    return f;
  endfunction

  task automatic modelReset();
    for (int g = 0; g < 8; g++) m_cnt[g] = 0;
    m_bank_ok[0] = 1'b0;
    m_bank_ok[1] = 1'b0;
    m_sel = 1'b0;
    m_swapping = 1'b0;
    m_err = 1'b0;
    m_bias_pend = 1'b0;
    m_rd_valid = 1'b0;
    m_ack = 1'b0;
    m_ready = 1'b1;
    m_active_bias = '0;
    m_rd_data = '0;
    m_accepted = 32'd0;
  endtask

  task automatic modelCycle(input logic [8:0] v, input logic [DW-1:0] d, input logic sw,
                            input logic ren, input logic [2:0] grp, input logic [3:0] tap);
    bit full_before;
    bit was_swapping;
    int ones;
    int g;
    full_before = allFull();
    was_swapping = m_swapping;
    ones = $countones(v);
    m_rd_valid = ren;
    if (ren) begin
      if (tap > 4'd8) begin
        m_rd_data = '0;
        m_err = 1'b1;
      end else begin
        m_rd_data = m_bank[m_sel][grp][tap];
      end
    end
    if (was_swapping) begin
      m_sel = !m_sel;
      m_bank_ok[m_sel] = 1'b1;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      if (m_bias_pend) begin
        m_active_bias = m_shadow_bias;
        m_bias_pend = 1'b0;
      end
    end
    if (ones > 1) begin
      m_err = 1'b1;
    end else if (v == 9'h100) begin
      m_shadow_bias = d;
      m_bias_pend = 1'b1;
      m_accepted = m_accepted + 32'd1;
    end else if (ones == 1) begin
      g = 0;
      for (int i = 0; i < 8; i++) if (v[i]) g = i;
      if (!was_swapping && !full_before && m_cnt[g] < 9) begin
        m_bank[!m_sel][g][m_cnt[g]] = d;
        m_cnt[g]++;
        m_accepted = m_accepted + 32'd1;
      end else begin
        m_err = 1'b1;
      end
    end
    m_ack = !was_swapping && full_before && sw;
    m_swapping = m_ack;
    m_ready = !(m_swapping || allFull());
  endtask

  task automatic checkOne(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkOne("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    checkOne("rd_data", 64'(rd_data), 64'(m_rd_data));
    checkOne("swap_ack", 64'(swap_ack), 64'(m_ack));
    checkOne("load_ready", 64'(load_ready), 64'(m_ready));
    checkOne("bank_error", 64'(bank_error), 64'(m_err));
    checkOne("active_bias", 64'(active_bias), 64'(m_active_bias));
`ifdef WEIGHT_BANK_DEBUG_CNT_EN
    checkOne("debug_cnt", 64'(debug_write_cnt), 64'(m_accepted));
`else
    checkOne("debug_cnt", 64'(debug_write_cnt), 64'd0);
`endif
  endtask

  task automatic applyStimulus(input logic [8:0] v, input logic [DW-1:0] d, input logic sw,
                               input logic ren, input logic [2:0] grp, input logic [3:0] tap);
    valid_in = v;
    data_in  = d;
    swap_req = sw;
    rd_en    = ren;
    rd_group = grp;
    rd_tap   = tap;
    modelCycle(v, d, sw, ren, grp, tap);
    @(posedge system_clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    valid_in = '0;
    data_in  = '0;
    swap_req = 1'b0;
    rd_en    = 1'b0;
    rd_group = '0;
    rd_tap   = '0;
    rst_n    = 1'b0;
    #2;
    modelReset();
    checkOutput();
    @(posedge system_clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Writes 72 words, group-major, data = base + running index; swap_req held from index swap_from on
  task automatic loadGroups(input int base, input int swap_from, input int count);
    int idx = 0;
    for (int g = 0; g < 8; g++) begin
      for (int t = 0; t < 9; t++) begin
        if (idx < count)
          applyStimulus(9'(1 << g), DW'(base + idx), (idx >= swap_from), 1'b0, 3'd0, 4'd0);
        idx++;
      end
    end
  endtask

  initial begin
    logic [8:0] v;
    logic [3:0] tap;
    logic       ren;
    int         r;
    valid_in = '0;
    data_in  = '0;
    swap_req = 1'b0;
    rd_en    = 1'b0;
    rd_group = '0;
    rd_tap   = '0;
    #1;
    doReset();
    applyStimulus(9'h000, '0, 1'b0, 1'b0, 3'd0, 4'd0);

    // Partial load interrupted by reset, then a fresh full load
    loadGroups(0, 1000, 20);
    doReset();
    loadGroups(0, 1000, 72);
    checkOne("full_load_ready", 64'(load_ready), 64'd0);
    checkOne("full_no_error", 64'(bank_error), 64'd0);

    // First swap with a preloaded bias, bias write landing in the SWAP cycle
    applyStimulus(9'h100, DW'(32'h11), 1'b0, 1'b0, 3'd0, 4'd0);
    applyStimulus(9'h000, '0, 1'b1, 1'b0, 3'd0, 4'd0);
    checkOne("swap_ack_pulse", 64'(swap_ack), 64'd1);
    applyStimulus(9'h100, DW'(32'hAB), 1'b0, 1'b0, 3'd0, 4'd0);
    checkOne("swap_ack_drop", 64'(swap_ack), 64'd0);
    checkOne("bias_promoted", 64'(active_bias), 64'h11);
    applyStimulus(9'h000, '0, 1'b0, 1'b1, 3'd3, 4'd5);
    checkOne("read_g3_t5", 64'(rd_data), 64'd32);

    // Swap requested mid-load stays pending until the bank is full
    loadGroups(100, 39, 72);
    checkOne("pending_no_ack", 64'(swap_ack), 64'd0);
    applyStimulus(9'h000, '0, 1'b1, 1'b1, 3'd3, 4'd5);
    checkOne("pending_ack", 64'(swap_ack), 64'd1);
    applyStimulus(9'h000, '0, 1'b0, 1'b1, 3'd3, 4'd5);
    checkOne("swap_cycle_read_old", 64'(rd_data), 64'd32);
    checkOne("second_bias", 64'(active_bias), 64'hAB);
    applyStimulus(9'h000, '0, 1'b0, 1'b1, 3'd3, 4'd5);
    checkOne("read_new_bank", 64'(rd_data), 64'd132);

    // Multi-hot valid and out-of-range tap both flag a sticky error
    applyStimulus(9'h003, DW'(32'h55), 1'b0, 1'b0, 3'd0, 4'd0);
    checkOne("multi_hot_error", 64'(bank_error), 64'd1);
    applyStimulus(9'h000, '0, 1'b0, 1'b1, 3'd0, 4'd12);
    checkOne("bad_tap_data", 64'(rd_data), 64'd0);
    checkOne("bad_tap_valid", 64'(rd_valid), 64'd1);
    applyStimulus(9'h000, '0, 1'b0, 1'b0, 3'd0, 4'd0);
    checkOne("error_sticky", 64'(bank_error), 64'd1);

    // Randomized traffic with a reset in the middle
    for (int n = 0; n < 700; n++) begin
      if (n == 350) doReset();
      r = int'($urandom_range(0, 15));
      if (r < 9)       v = 9'(1 << $urandom_range(0, 7));
      else if (r == 9) v = 9'h100;
      else if (r == 10) v = 9'($urandom_range(1, 511));
      else             v = 9'h000;
      tap = 4'($urandom_range(0, 10));
      ren = ($urandom_range(0, 1) == 1) && (m_bank_ok[m_sel] || tap > 4'd8);
      applyStimulus(v, DW'($urandom), ($urandom_range(0, 3) == 0), ren,
                    3'($urandom_range(0, 7)), tap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
